// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Drives datapath latch enables and the imem/dmem request handshakes, with a
// memory wait timeout that parks the machine in HALT with a sticky error.
// Optional performance counters are built when MULTICYCLE_CTRL_PERF_CNT_EN is defined.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_WIDTH   = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       isLoad,
   input  logic       isStore,
   input  logic       isBranch,
   input  logic       brTaken,
   input  logic       imemReady,
   input  logic       dmemReady,
   output logic       imemReq,
   output logic       irWrEnable,
   output logic       aluRegWrEnable,
   output logic       pcWrEnable,
   output logic       pcSelBranch,
   output logic       dmemReq,
   output logic       dataWrEnable,
   output logic       rfWrEnable,
   output logic       rfWrSelLoad,
   output logic [2:0] state,
   output logic       timeoutErr
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] cycleCount,
   output logic [CNT_WIDTH-1:0] retiredCount
`endif
);

   // Wait counter only needs to reach MEM_TIMEOUT; it saturates at all-ones.
   localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] TO_VAL = WCW'(MEM_TIMEOUT);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t         state_q, state_d;
   logic [WCW-1:0] wcnt_q, wcnt_d, wcnt_inc;
   logic           to_q, to_d;
   logic           to_hit;

   logic imem_c, ir_c, alu_c, pcw_c, pcs_c, dmem_c, dw_c, rfw_c, rfs_c;

   // Next state, wait counter and the raw (pre-reset-mask) control outputs.
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      to_d     = to_q;
      imem_c   = 1'b0;
      ir_c     = 1'b0;
      alu_c    = 1'b0;
      pcw_c    = 1'b0;
      pcs_c    = 1'b0;
      dmem_c   = 1'b0;
      dw_c     = 1'b0;
      rfw_c    = 1'b0;
      rfs_c    = 1'b0;
      wcnt_inc = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;
      to_hit   = (MEM_TIMEOUT != 0) && (wcnt_q == TO_VAL);
      case (state_q)
         S_FETCH: begin
            imem_c = 1'b1;
            if (imemReady) begin
               ir_c    = 1'b1;
               state_d = S_DECODE;
               wcnt_d  = '0;
            end else if (to_hit) begin
               state_d = S_HALT;
               to_d    = 1'b1;
            end else begin
               wcnt_d = wcnt_inc;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
            wcnt_d  = '0;
         end
         S_EXEC: begin
            alu_c  = 1'b1;
            wcnt_d = '0;
            // Branch overrides memory classes; load wins over store later in MEM.
            if (isBranch) begin
               pcw_c   = 1'b1;
               pcs_c   = brTaken;
               state_d = S_FETCH;
            end else if (isLoad || isStore) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            dmem_c = 1'b1;
            dw_c   = isStore & ~isLoad;
            if (dmemReady) begin
               wcnt_d = '0;
               if (isLoad) begin
                  state_d = S_WB;
               end else begin
                  pcw_c   = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (to_hit) begin
               state_d = S_HALT;
               to_d    = 1'b1;
            end else begin
               wcnt_d = wcnt_inc;
            end
         end
         S_WB: begin
            rfw_c   = 1'b1;
            rfs_c   = isLoad;
            pcw_c   = 1'b1;
            state_d = S_FETCH;
            wcnt_d  = '0;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
            wcnt_d  = '0;
         end
      endcase
   end

   // State, wait counter and sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         wcnt_q  <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         to_q    <= to_d;
      end
   end

   // Reset masks every control output immediately, not just at the next edge.
   assign imemReq        = imem_c & ~rst;
   assign irWrEnable     = ir_c   & ~rst;
   assign aluRegWrEnable = alu_c  & ~rst;
   assign pcWrEnable     = pcw_c  & ~rst;
   assign pcSelBranch    = pcs_c  & ~rst;
   assign dmemReq        = dmem_c & ~rst;
   assign dataWrEnable   = dw_c   & ~rst;
   assign rfWrEnable     = rfw_c  & ~rst;
   assign rfWrSelLoad    = rfs_c  & ~rst;
   assign state          = state_q;
   assign timeoutErr     = to_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] cyc_q, cyc_d, ret_q, ret_d;

   // Cycle count stops in HALT; retired count tracks PC writes. Both wrap.
   always_comb begin
      cyc_d = (state_q != S_HALT) ? cyc_q + 1'b1 : cyc_q;
      ret_d = pcWrEnable ? ret_q + 1'b1 : ret_q;
   end

   // Performance counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         ret_q <= ret_d;
      end
   end

   assign cycleCount   = cyc_q;
   assign retiredCount = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is expanded
// into an expected per-cycle trace (inputs to drive + outputs to expect) from
// its class and chosen memory wait lengths; the trace is replayed against the DUT.
module tb_multicycle_controller;
   localparam int TO = 15;
   localparam int CW = 32;

   logic clk = 1'b0;
   logic rst;
   logic isLoad, isStore, isBranch, brTaken, imemReady, dmemReady;
   logic imemReq, irWrEnable, aluRegWrEnable, pcWrEnable, pcSelBranch;
   logic dmemReq, dataWrEnable, rfWrEnable, rfWrSelLoad;
   logic [2:0] state;
   logic timeoutErr;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
   logic [CW-1:0] cycleCount, retiredCount;
`endif

   multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .isLoad(isLoad), .isStore(isStore), .isBranch(isBranch), .brTaken(brTaken),
      .imemReady(imemReady), .dmemReady(dmemReady),
      .imemReq(imemReq), .irWrEnable(irWrEnable), .aluRegWrEnable(aluRegWrEnable),
      .pcWrEnable(pcWrEnable), .pcSelBranch(pcSelBranch), .dmemReq(dmemReq),
      .dataWrEnable(dataWrEnable), .rfWrEnable(rfWrEnable), .rfWrSelLoad(rfWrSelLoad),
      .state(state), .timeoutErr(timeoutErr)
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
      , .cycleCount(cycleCount), .retiredCount(retiredCount)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // {imemReq, irWr, aluRegWr, pcWr, pcSelBranch, dmemReq, dataWr, rfWr, rfWrSelLoad}
   wire [8:0] outv = {imemReq, irWrEnable, aluRegWrEnable, pcWrEnable, pcSelBranch,
                      dmemReq, dataWrEnable, rfWrEnable, rfWrSelLoad};

   function automatic logic [8:0] ov(bit im, bit ir, bit al, bit pw, bit ps,
                                     bit dm, bit dw, bit rw, bit rs);
      return {im, ir, al, pw, ps, dm, dw, rw, rs};
   endfunction

   typedef struct packed {
      logic i_ld, i_st, i_br, i_bt, i_ir, i_dr;
      logic [8:0] e_out;
      logic [2:0] e_state;
      logic       e_to;
   } row_t;

   row_t q[$];
   int unsigned ecyc, eret;

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   task automatic push(input logic ld, input logic st, input logic br, input logic bt,
                       input logic ir, input logic dr, input logic [8:0] e,
                       input logic [2:0] s, input logic t);
      row_t r;
      r.i_ld = ld; r.i_st = st; r.i_br = br; r.i_bt = bt; r.i_ir = ir; r.i_dr = dr;
      r.e_out = e; r.e_state = s; r.e_to = t;
      q.push_back(r);
   endtask

   task automatic push_fwait(input int n);
      for (int k = 0; k < n; k++)
         push(rb(), rb(), rb(), rb(), 1'b0, rb(), ov(1,0,0,0,0,0,0,0,0), 3'd0, 1'b0);
   endtask

   task automatic push_halt(input int n);
      for (int k = 0; k < n; k++)
         push(rb(), rb(), rb(), rb(), rb(), rb(), 9'd0, 3'd5, 1'b1);
   endtask

   // kind: 0 ALU, 1 taken branch, 2 load, 3 store, 4 load+store, 5 untaken branch
   task automatic gen_instr(input int kind, input int wi, input int wd, input bit mem_hang);
      logic ld, st, br, bt, sto;
      ld  = (kind == 2) || (kind == 4);
      st  = (kind == 3) || (kind == 4);
      br  = (kind == 1) || (kind == 5);
      bt  = (kind == 1);
      if (br) begin ld = rb(); st = rb(); end
      sto = st & ~ld;
      push_fwait(wi);
      push(rb(), rb(), rb(), rb(), 1'b1, rb(), ov(1,1,0,0,0,0,0,0,0), 3'd0, 1'b0);
      push(ld, st, br, bt, rb(), rb(), 9'd0, 3'd1, 1'b0);
      push(ld, st, br, bt, rb(), rb(), ov(0,0,1,br,br&bt,0,0,0,0), 3'd2, 1'b0);
      if (!br && (ld || st)) begin
         for (int k = 0; k < (mem_hang ? TO + 1 : wd); k++)
            push(ld, st, br, bt, rb(), 1'b0, ov(0,0,0,0,0,1,sto,0,0), 3'd3, 1'b0);
         if (mem_hang) push_halt(10);
         else push(ld, st, br, bt, rb(), 1'b1, ov(0,0,0,sto,0,1,sto,0,0), 3'd3, 1'b0);
      end
      if (!br && !sto && !mem_hang)
         push(ld, st, br, bt, rb(), rb(), ov(0,0,0,1,0,0,0,1,ld), 3'd4, 1'b0);
   endtask

   task automatic drive(input row_t r);
      isLoad = r.i_ld; isStore = r.i_st; isBranch = r.i_br; brTaken = r.i_bt;
      imemReady = r.i_ir; dmemReady = r.i_dr;
   endtask

   // Replays up to n queued rows; entered and left at posedge+1.
   task automatic run_rows(input int n);
      row_t r;
      for (int k = 0; k < n && q.size() > 0; k++) begin
         r = q.pop_front();
         drive(r);
         @(negedge clk);
         chk("outputs", 32'(outv), 32'(r.e_out));
         chk("state", 32'(state), 32'(r.e_state));
         chk("timeoutErr", 32'(timeoutErr), 32'(r.e_to));
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
         chk("cycleCount", cycleCount, ecyc);
         chk("retiredCount", retiredCount, eret);
`endif
         if (r.e_state != 3'd5) ecyc++;
         if (r.e_out[5]) eret++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      isLoad = 1'b1; isStore = 1'b1; isBranch = 1'b0; brTaken = 1'b1;
      imemReady = 1'b1; dmemReady = 1'b1;
      #1;
      chk("rst_outputs_async", 32'(outv), 32'd0);
      @(negedge clk);
      chk("rst_outputs", 32'(outv), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_timeoutErr", 32'(timeoutErr), 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
      chk("rst_cycleCount", cycleCount, 32'd0);
      chk("rst_retiredCount", retiredCount, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst  = 1'b0;
      ecyc = 0;
      eret = 0;
   endtask

   initial begin
      rst = 1'b1;
      do_reset();

      // Directed: one of each class, then wait-length boundaries.
      gen_instr(0, 0, 0, 0);
      gen_instr(2, 0, 3, 0);
      gen_instr(1, 0, 0, 0);
      gen_instr(5, 0, 0, 0);
      gen_instr(3, 0, 0, 0);
      gen_instr(4, 0, 1, 0);
      gen_instr(0, TO, 0, 0);   // imem ready on the last allowed cycle
      gen_instr(3, 0, TO, 0);   // dmem ready on the last allowed cycle
      run_rows(1000);

      // Random instruction mix with occasional long waits.
      for (int n = 0; n < 60; n++) begin
         int kind, wi, wd;
         kind = int'($urandom_range(0, 5));
         wi   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO)) : 0;
         wd   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TO)) : int'($urandom_range(0, 2));
         gen_instr(kind, wi, wd, 0);
      end
      run_rows(5000);

      // imem never ready: 16 cycles in FETCH, then HALT held with sticky error.
      push_fwait(TO + 1);
      push_halt(50);
      run_rows(1000);
      do_reset();

      // dmem never ready on a load: HALT from MEM.
      gen_instr(2, 2, 0, 1);
      run_rows(1000);
      do_reset();

      // Reset asserted mid-store while in MEM: requests drop immediately.
      gen_instr(3, 0, 5, 0);
      run_rows(3);
      drive(q.pop_front());
      #2;
      chk("mem_req_before_rst", 32'({dmemReq, dataWrEnable, state}), 32'({2'b11, 3'd3}));
      rst = 1'b1;
      #1;
      chk("mem_req_after_rst", 32'({dmemReq, dataWrEnable, state}), 32'd0);
      q.delete();
      @(posedge clk);
      #1;
      do_reset();
      gen_instr(0, 1, 0, 0);
      run_rows(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
